// File: rtl/sram_pkg.sv
// Shared SRAM bus definitions: geometry, write-side FSM states and the request
// record passed between the write port, the reader and the bus arbiter.
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] data;
        logic [1:0]         be;
    } sram_req_t;

endpackage

// File: rtl/sram_write_fifo.sv
// Small synchronous FIFO of SRAM write requests. Exposes the head entry and the
// entry behind it so the write FSM can chain cycles without an idle gap.
module sram_write_fifo
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  sram_req_t     push_req,
    input  logic          pop,
    output sram_req_t     head_req,
    output sram_req_t     next_req,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_next
);

    localparam int PW = $clog2(FIFO_DEPTH);

    sram_req_t         mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     nxt_ptr;
    logic [LW-1:0]     level_q, level_d;

    // Callers never push when full nor pop when empty, so no guards here.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        nxt_ptr  = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    assign head_req   = mem_q[rd_ptr_q];
    assign next_req   = mem_q[nxt_ptr];
    assign full       = (level_q == LW'(FIFO_DEPTH));
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/sram_write_port.sv
// Write side of the shared async-SRAM bus: buffers requests and runs
// SETUP/PULSE/HOLD write cycles while the video side grants the bus.
module sram_write_port
    import sram_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [SRAM_AW-1:0] wr_addr,
    input  logic [SRAM_DW-1:0] wr_data,
    input  logic [1:0]         wr_be,
    input  logic               bus_grant,
    output logic               bus_req,
    output logic [SRAM_AW-1:0] ram_addr,
    output logic [SRAM_DW-1:0] ram_dout,
    output logic               ram_ce,
    output logic               ram_oe,
    output logic               ram_we,
    output logic               ram_lb,
    output logic               ram_hb,
    output logic               ram_drive,
    output logic               busy,
    output logic [LW-1:0]      level
);

    localparam int CW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    wr_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pop;
    logic               push;
    sram_req_t          push_req;
    sram_req_t          head_req;
    sram_req_t          next_req;
    sram_req_t          active_req;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LW-1:0]      level_next;

    logic               wr_ready_q, wr_ready_d;
    logic [SRAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [SRAM_DW-1:0] ram_dout_q, ram_dout_d;
    logic               ram_ce_q, ram_ce_d;
    logic               ram_we_q, ram_we_d;
    logic               ram_lb_q, ram_lb_d;
    logic               ram_hb_q, ram_hb_d;
    logic               ram_drive_q, ram_drive_d;

    assign push     = wr_valid & wr_ready_q;
    assign push_req = '{addr: wr_addr, data: wr_data, be: wr_be};

    sram_write_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_req   (push_req),
        .pop        (pop),
        .head_req   (head_req),
        .next_req   (next_req),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (level),
        .level_next (level_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The head is only popped once its cycle has fully finished (HOLD exit),
    // so a chained cycle takes its fields from the entry behind the head.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_req.be == 2'b00) begin
                        pop = 1'b1;
                    end else if (bus_grant) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            PULSE: begin
                if (cnt_q == CW'(WE_CYCLES - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                pop = 1'b1;
                if (bus_grant && (level >= LW'(2)) && (next_req.be != 2'b00)) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pins are computed from the next state so their registers line up
    // cycle-for-cycle with state_q.
    always_comb begin
        active_req  = (state_q == HOLD) ? next_req : head_req;
        ram_ce_d    = (state_d == IDLE);
        ram_we_d    = (state_d != PULSE);
        ram_drive_d = (state_d != IDLE);
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_lb_d    = ram_lb_q;
        ram_hb_d    = ram_hb_q;
        if (state_d == SETUP) begin
            ram_addr_d = active_req.addr;
            ram_dout_d = active_req.data;
            ram_lb_d   = ~active_req.be[0];
            ram_hb_d   = ~active_req.be[1];
        end else if (state_d == IDLE) begin
            ram_lb_d = 1'b1;
            ram_hb_d = 1'b1;
        end
        wr_ready_d = (level_next != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ready_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_ce_q    <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_lb_q    <= 1'b1;
            ram_hb_q    <= 1'b1;
            ram_drive_q <= 1'b0;
        end else begin
            wr_ready_q  <= wr_ready_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_lb_q    <= ram_lb_d;
            ram_hb_q    <= ram_hb_d;
            ram_drive_q <= ram_drive_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign ram_ce    = ram_ce_q;
    assign ram_oe    = 1'b1;
    assign ram_we    = ram_we_q;
    assign ram_lb    = ram_lb_q;
    assign ram_hb    = ram_hb_q;
    assign ram_drive = ram_drive_q;
    assign busy      = (state_q != IDLE);
    assign bus_req   = (level != '0) | busy;

endmodule

// File: tb/tb_sram_write_port.sv
// Directed bench for sram_write_port (FIFO_DEPTH=4, WE_CYCLES=2): inputs change
// just after rising edges, outputs are sampled on falling edges.
module tb_sram_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        bus_grant;
    logic        bus_req;
    logic [17:0] ram_addr;
    logic [15:0] ram_dout;
    logic        ram_ce, ram_oe, ram_we, ram_lb, ram_hb, ram_drive;
    logic        busy;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_write_port #(
        .FIFO_DEPTH (4),
        .WE_CYCLES  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .bus_grant (bus_grant),
        .bus_req   (bus_req),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_ce    (ram_ce),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_lb    (ram_lb),
        .ram_hb    (ram_hb),
        .ram_drive (ram_drive),
        .busy      (busy),
        .level     (level)
    );

    task automatic push_one(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic fill_four(input logic [17:0] base);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = base + 18'(i); wr_data = 16'h1000 + 16'(i); wr_be = 2'b11;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic drain;
        bit done;
        done = 1'b0;
        bus_grant = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (level == 3'd0 && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL drain_timeout level=%0d busy=%b want 0/0", level, busy); end
        bus_grant = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bit hit;
        // Values held in reset from time zero
        @(negedge clk);
        checks++; if (ram_ce !== 1'b1) begin errors++; $display("FAIL rst_ce got %b want 1", ram_ce); end
        checks++; if (ram_we !== 1'b1 || ram_oe !== 1'b1) begin errors++; $display("FAIL rst_we_oe got %b%b want 11", ram_we, ram_oe); end
        checks++; if (ram_lb !== 1'b1 || ram_hb !== 1'b1) begin errors++; $display("FAIL rst_lbhb got %b%b want 11", ram_lb, ram_hb); end
        checks++; if (ram_addr !== 18'h0 || ram_dout !== 16'h0) begin errors++; $display("FAIL rst_addr_dout got %h/%h want 0/0", ram_addr, ram_dout); end
        checks++; if (ram_drive !== 1'b0 || bus_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctl got %b%b%b want 000", ram_drive, bus_req, busy); end
        checks++; if (level !== 3'd0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rst_level_ready got %0d/%b want 0/0", level, wr_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", wr_ready); end

        // Reset mid-write with a full FIFO
        @(posedge clk); #1;
        fill_four(18'h00100);
        @(negedge clk);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL rstfull_level got %0d want 4", level); end
        bus_grant = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (ram_we == 1'b0) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstfull_pulse_timeout we=%b want 0", ram_we); end
        #2 reset = 1'b1;
        #1;
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rstasync_level got %0d want 0", level); end
        checks++; if (ram_we !== 1'b1 || ram_ce !== 1'b1) begin errors++; $display("FAIL rstasync_we_ce got %b%b want 11", ram_we, ram_ce); end
        checks++; if (ram_drive !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL rstasync_ctl got drive=%b busy=%b rdy=%b want 000", ram_drive, busy, wr_ready); end
        bus_grant = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rstrel_ready_early got %b want 0", wr_ready); end
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL rstrel_ready got %b lvl=%0d want 1/0", wr_ready, level); end
    endtask

    task automatic test_single_write;
        bus_grant = 1'b1;
        @(posedge clk); #1;
        push_one(18'h12345, 16'hBEEF, 2'b11);
        for (int k = 0; k < 6; k++) begin
            logic ed, ew;
            @(negedge clk);
            ed = (k >= 1 && k <= 4);
            ew = !(k == 2 || k == 3);
            checks++; if (ram_drive !== ed || busy !== ed) begin errors++; $display("FAIL single_drive k=%0d got %b/%b want %b", k, ram_drive, busy, ed); end
            checks++; if (ram_ce !== !ed) begin errors++; $display("FAIL single_ce k=%0d got %b want %b", k, ram_ce, !ed); end
            checks++; if (ram_we !== ew) begin errors++; $display("FAIL single_we k=%0d got %b want %b", k, ram_we, ew); end
            if (ed) begin
                checks++; if (ram_addr !== 18'h12345 || ram_dout !== 16'hBEEF) begin errors++; $display("FAIL single_addr_data k=%0d got %h/%h want 12345/beef", k, ram_addr, ram_dout); end
                checks++; if (ram_lb !== 1'b0 || ram_hb !== 1'b0) begin errors++; $display("FAIL single_lbhb k=%0d got %b%b want 00", k, ram_lb, ram_hb); end
            end
        end
        checks++; if (level !== 3'd0 || bus_req !== 1'b0) begin errors++; $display("FAIL single_end got lvl=%0d req=%b want 0/0", level, bus_req); end
        bus_grant = 1'b0;
    endtask

    task automatic test_byte_write;
        bus_grant = 1'b1;
        @(posedge clk); #1;
        push_one(18'h00AB0, 16'h5A5A, 2'b10);
        repeat (3) @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL byte_we got %b want 0", ram_we); end
        checks++; if (ram_hb !== 1'b0 || ram_lb !== 1'b1) begin errors++; $display("FAIL byte_hb_lb got %b%b want 01", ram_hb, ram_lb); end
        repeat (3) @(negedge clk);
        checks++; if (ram_hb !== 1'b1 || ram_lb !== 1'b1 || ram_drive !== 1'b0) begin errors++; $display("FAIL byte_idle got hb=%b lb=%b drv=%b want 110", ram_hb, ram_lb, ram_drive); end
        bus_grant = 1'b0;
    endtask

    task automatic test_zero_be;
        bit ce_seen;
        bus_grant = 1'b1;
        @(posedge clk); #1;
        push_one(18'h00777, 16'h1234, 2'b00);
        @(negedge clk);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL zero_level_pre got %0d want 1", level); end
        ce_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ram_ce == 1'b0 || busy == 1'b1) ce_seen = 1'b1;
            if (k == 0) begin
                checks++; if (level !== 3'd0) begin errors++; $display("FAIL zero_popped got %0d want 0", level); end
            end
        end
        checks++; if (ce_seen) begin errors++; $display("FAIL zero_no_cycle got ce_low=1 want 0"); end
        bus_grant = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit hit;
        @(posedge clk); #1;
        push_one(18'h00010, 16'hA001, 2'b11);
        push_one(18'h00020, 16'hA002, 2'b01);
        push_one(18'h00030, 16'hA003, 2'b11);
        @(negedge clk);
        checks++; if (level !== 3'd3 || busy !== 1'b0) begin errors++; $display("FAIL b2b_queued got %0d/%b want 3/0", level, busy); end
        bus_grant = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 5 && !hit; i++) begin
            @(negedge clk);
            if (busy) hit = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL b2b_start_timeout busy=%b want 1", busy); end
        for (int i = 0; i < 13; i++) begin
            logic       ew;
            logic [17:0] ea;
            if (i > 0) @(negedge clk);
            ew = !((i % 4) == 1 || (i % 4) == 2);
            ea = 18'h00010 * 18'(i / 4 + 1);
            if (i < 12) begin
                checks++; if (busy !== 1'b1 || ram_drive !== 1'b1) begin errors++; $display("FAIL b2b_busy i=%0d got %b/%b want 1/1", i, busy, ram_drive); end
                checks++; if (ram_we !== ew) begin errors++; $display("FAIL b2b_we i=%0d got %b want %b", i, ram_we, ew); end
                checks++; if (ram_addr !== ea) begin errors++; $display("FAIL b2b_addr i=%0d got %h want %h", i, ram_addr, ea); end
            end else begin
                checks++; if (busy !== 1'b0 || ram_drive !== 1'b0) begin errors++; $display("FAIL b2b_end got %b/%b want 0/0", busy, ram_drive); end
            end
        end
        bus_grant = 1'b0;
    endtask

    task automatic test_grant;
        bit hit;
        @(posedge clk); #1;
        push_one(18'h00200, 16'hC001, 2'b11);
        push_one(18'h00201, 16'hC002, 2'b11);
        repeat (3) @(negedge clk);
        checks++; if (ram_ce !== 1'b1 || ram_drive !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL grant_low_idle got ce=%b drv=%b busy=%b want 100", ram_ce, ram_drive, busy); end
        checks++; if (bus_req !== 1'b1 || level !== 3'd2) begin errors++; $display("FAIL grant_low_req got %b/%0d want 1/2", bus_req, level); end
        bus_grant = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 6 && !hit; i++) begin
            @(negedge clk);
            if (ram_we == 1'b0) hit = 1'b1;
        end
        checks++; if (!hit || ram_addr !== 18'h00200) begin errors++; $display("FAIL grant_start got hit=%b addr=%h want 1/00200", hit, ram_addr); end
        bus_grant = 1'b0;
        @(negedge clk);
        checks++; if (ram_we !== 1'b0 || ram_drive !== 1'b1) begin errors++; $display("FAIL grant_drop_pulse got we=%b drv=%b want 0/1", ram_we, ram_drive); end
        @(negedge clk);
        checks++; if (ram_we !== 1'b1 || ram_drive !== 1'b1 || level !== 3'd2) begin errors++; $display("FAIL grant_drop_hold got we=%b drv=%b lvl=%0d want 1/1/2", ram_we, ram_drive, level); end
        @(negedge clk);
        checks++; if (ram_drive !== 1'b0 || ram_ce !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL grant_drop_done got drv=%b ce=%b lvl=%0d want 0/1/1", ram_drive, ram_ce, level); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || bus_req !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL grant_second_waits got busy=%b req=%b lvl=%0d want 0/1/1", busy, bus_req, level); end
        drain();
    endtask

    task automatic test_full;
        bit hit;
        logic prev_ready;
        @(posedge clk); #1;
        fill_four(18'h00300);
        @(negedge clk);
        checks++; if (level !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_flags got lvl=%0d rdy=%b want 4/0", level, wr_ready); end
        wr_valid = 1'b1; wr_addr = 18'h00399; wr_data = 16'hDEAD; wr_be = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (level !== 3'd4 || wr_ready !== 1'b0) begin errors++; $display("FAIL full_reject got lvl=%0d rdy=%b want 4/0", level, wr_ready); end
        wr_valid = 1'b0;
        bus_grant = 1'b1;
        hit = 1'b0;
        prev_ready = wr_ready;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (level == 3'd3) hit = 1'b1;
            else prev_ready = wr_ready;
        end
        checks++; if (!hit) begin errors++; $display("FAIL full_pop_timeout lvl=%0d want 3", level); end
        checks++; if (prev_ready !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_return got before=%b after=%b want 0/1", prev_ready, wr_ready); end
        drain();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_drained_ready got %b want 1", wr_ready); end
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; bus_grant = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single_write();
        test_byte_write();
        test_zero_be();
        test_back_to_back();
        test_grant();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached want finish");
        $fatal(1);
    end

endmodule

// File: doc/sram_write_port.md
Name: sram_write_port

Overview:
- Write-side counterpart to the background layer's SRAM reader.
- Accepts pixel/tile write requests on the `clk` domain over a valid/ready handshake and buffers them in a small FIFO.
- Executes asynchronous-SRAM write cycles on the shared 256Kx16 bus, but only while the video side grants the bus (e.g. outside active fetch windows).
- Drives the same ram_* pin set as the reader; the top level muxes the two onto the pins using ram_drive.

Parameters:
- FIFO_DEPTH, 4: request buffer entries; power of two, at least 2.
- WE_CYCLES, 2: clk cycles ram_we is held low per write; at least 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request present
- wr_ready  out  1  FIFO can accept a request (high = not full)
- wr_addr  in  18  SRAM word address
- wr_data  in  16  write data
- wr_be  in  2  byte enables; bit0 = low byte, bit1 = high byte
- bus_grant  in  1  video side releases the SRAM bus
- bus_req  out  1  FIFO non-empty or write cycle in progress
- ram_addr  out  18  SRAM address
- ram_dout  out  16  SRAM write data
- ram_ce  out  1  chip enable, active-low
- ram_oe  out  1  output enable, active-low; never asserted by this block
- ram_we  out  1  write enable, active-low
- ram_lb  out  1  low byte select, active-low
- ram_hb  out  1  high byte select, active-low
- ram_drive  out  1  this block owns the pins and drives the data bus
- busy  out  1  write cycle in progress (state not IDLE)
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async) values:
  - ram_ce, ram_oe, ram_we, ram_lb, ram_hb = 1.
  - ram_addr = 0, ram_dout = 0.
  - ram_drive = 0, bus_req = 0, busy = 0, level = 0, wr_ready = 0.
  - wr_ready rises to 1 on the first clk edge after reset deasserts.
  - FIFO contents are discarded.
- Reset mid-cycle: all pins return to inactive immediately (asynchronously) and the partial write is abandoned.
- All outputs are registered.
- FIFO push: wr_valid & wr_ready on a clk edge.
  - wr_ready = !full, registered.
  - A pop in the same cycle as full does not raise wr_ready until the next cycle.
  - Simultaneous push and pop when not full: level is unchanged.
- Zero byte enables: an entry with wr_be == 0 is popped with no bus cycle (IDLE consumes it in 1 cycle) and is not counted as a write.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE -> SETUP when FIFO non-empty, head wr_be != 0, and bus_grant = 1.
  - SETUP (1 cycle): ram_drive = 1, ram_ce = 0; addr/data/lb/hb driven from the FIFO head; ram_we = 1.
  - PULSE (WE_CYCLES cycles): ram_we = 0; addr, data and byte selects stable.
  - HOLD (1 cycle): ram_we = 1, data still driven; the FIFO head is popped on exit.
  - HOLD -> SETUP if bus_grant = 1 and another non-zero-be entry is present (back-to-back). Otherwise HOLD -> IDLE, where ram_drive = 0 and ce/lb/hb return to 1.
- Write-cycle length: WE_CYCLES+2 clk cycles from SETUP entry to HOLD exit.
- Grant drop: bus_grant falling during SETUP, PULSE or HOLD does not abort; the cycle completes. The video side guarantees WE_CYCLES+2 cycles of margin.
- Byte selects: ram_lb = !wr_be[0], ram_hb = !wr_be[1] of the active entry.
- Address and data pass through unchanged; no address arithmetic; no wrap handling is needed (18-bit address).
- bus_req: high whenever level != 0 or busy; combinational from registered state.

Decomposition:
- Shared package (sram_pkg):
  - SRAM_AW = 18, SRAM_DW = 16.
  - write-state enum {IDLE, SETUP, PULSE, HOLD}.
  - packed request struct {addr, data, be}; later reused by the reader and by the arbiter.
- Sub-module sram_write_fifo: synchronous FIFO of request structs, FIFO_DEPTH entries, with full/empty/level flags.
- The FSM and pin registers stay in sram_write_port.

Test Plan:
- Reset with a full FIFO, WE_CYCLES = 2:
  - Stimulus: fill 4 entries, assert reset.
  - Response: level = 0, ram_we = ram_ce = 1, ram_drive = 0 the same cycle; wr_ready = 1 one cycle after release.
- Single write:
  - Stimulus: addr 0x12345, data 0xBEEF, be 2'b11, grant held high.
  - Response: SETUP 1 cycle, ram_we low exactly 2 cycles, HOLD 1 cycle; ram_addr = 0x12345 and ram_dout = 0xBEEF stable throughout; lb = hb = 0.
- Byte write:
  - be 2'b10 -> ram_hb = 0, ram_lb = 1 during the cycle.
  - be 2'b00 -> popped in 1 cycle; ram_ce never goes low.
- Back-to-back:
  - Stimulus: 3 queued writes, grant high.
  - Response: 12 consecutive busy cycles; ram_drive never drops between writes; ram_we pulses with 2-cycle gaps (HOLD + SETUP).
- Grant handling:
  - Grant low with 2 queued entries: no bus activity and bus_req = 1.
  - Grant rises: first write starts.
  - Grant drops in PULSE: that write completes, the second waits in IDLE.
- Full FIFO:
  - Stimulus: push 4 with grant low.
  - Response: wr_ready = 0 and a 5th valid is not accepted (level stays 4). After one pop, wr_ready returns to 1 the following cycle.
